// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one combinational ALU between the integer
// issue path (req0) and the branch-compare path (req1), with a tagged response.
module alu_share_arb #(
  parameter int             WIDTH  = 32,
  parameter int             OPW    = 5,
  parameter logic [OPW-1:0] MAX_OP = 5'b01111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   id;
  logic   any_valid;
  logic   grant_id;

  // Under contention the requester that did not win last time is favoured.
  assign any_valid  = req0_valid | req1_valid;
  assign grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && req1_valid && grant_id;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id         <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_a      <= grant_id ? req1_a  : req0_a;
            alu_b      <= grant_id ? req1_b  : req0_b;
            alu_op     <= grant_id ? req1_op : req0_op;
            id         <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id;
          // Illegal opcodes never expose the ALU output.
          if (alu_op > MAX_OP) begin
            rsp_err  <= 1'b1;
            rsp_y    <= '0;
            rsp_zero <= 1'b1;
          end else begin
            rsp_err  <= 1'b0;
            rsp_y    <= alu_y;
            rsp_zero <= alu_zero;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: a transaction model predicts grants and
// responses, and a separate monitor compares whatever the DUT presents.
module tb_alu_share_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [4:0]  alu_op;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [31:0] rsp_y;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    logic        id;
    logic [31:0] y;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opcode map of the shared ALU: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR,
  // 6 SRL, 7 SRA, 8 OR, 9 AND, other legal codes pass operand B.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] op);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a << b[4:0];
      5'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4:    return (a < b) ? 32'd1 : 32'd0;
      5'd5:    return a ^ b;
      5'd6:    return a >> b[4:0];
      5'd7:    return 32'($signed(a) >>> b[4:0]);
      5'd8:    return a | b;
      5'd9:    return a & b;
      default: return b;
    endcase
  endfunction

  assign alu_y    = alu_fn(alu_a, alu_b, alu_op);
  assign alu_zero = (alu_y == 32'd0);

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [4:0] op0, input logic v1, input logic [31:0] a1,
                               input logic [31:0] b1, input logic [4:0] op1,
                               input logic rr, input int cycles);
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready  = rr;
    repeat (cycles - 1) @(negedge clk);
  endtask

  // Transaction model: one operation in flight at a time; its response is
  // visible one edge after acceptance and retires on an edge with rsp_ready.
  logic        m_inflight = 1'b0;
  logic        m_age      = 1'b0;
  logic        m_last     = 1'b1;
  logic [31:0] m_a = '0, m_b = '0;
  logic [4:0]  m_op = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight = 1'b0;
      m_age      = 1'b0;
      m_last     = 1'b1;
      m_a = '0; m_b = '0; m_op = '0;
      exp_q.delete();
    end else if (m_inflight) begin
      if (!m_age) m_age = 1'b1;
      else if (rsp_ready) m_inflight = 1'b0;
    end else if (req0_valid || req1_valid) begin
      logic pick;
      exp_t e;
      pick = (req0_valid && req1_valid) ? !m_last : req1_valid;
      m_a  = pick ? req1_a : req0_a;
      m_b  = pick ? req1_b : req0_b;
      m_op = pick ? req1_op : req0_op;
      e.id   = pick;
      e.err  = (m_op > 5'd15);
      e.y    = e.err ? 32'd0 : alu_fn(m_a, m_b, m_op);
      e.zero = (e.y == 32'd0);
      exp_q.push_back(e);
      m_last     = pick;
      m_inflight = 1'b1;
      m_age      = 1'b0;
    end
  end

  // Monitor: handshake/status each cycle, responses popped on first sight.
  logic        rsp_seen = 1'b0;
  logic [34:0] rsp_hold;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      rsp_seen = 1'b0;
    end else begin
      logic g;
      g = (req0_valid && req1_valid) ? !m_last : req1_valid;
      checkOutput("req0_ready", 80'(req0_ready), 80'(!m_inflight && req0_valid && !g));
      checkOutput("req1_ready", 80'(req1_ready), 80'(!m_inflight && req1_valid && g));
      checkOutput("busy", 80'(busy), 80'(m_inflight));
      checkOutput("rsp_valid", 80'(rsp_valid), 80'(m_inflight && m_age));
      checkOutput("alu_operands", 80'({alu_a, alu_b, alu_op}), 80'({m_a, m_b, m_op}));
      if (rsp_valid) begin
        if (!rsp_seen) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_rsp", 80'(1), 80'(0));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            rsp_hold = {e.id, e.y, e.zero, e.err};
            checkOutput("rsp_fields", 80'({rsp_id, rsp_y, rsp_zero, rsp_err}), 80'(rsp_hold));
          end
          rsp_seen = 1'b1;
        end else begin
          checkOutput("rsp_stable", 80'({rsp_id, rsp_y, rsp_zero, rsp_err}), 80'(rsp_hold));
        end
      end else begin
        rsp_seen = 1'b0;
      end
    end
  end

  initial begin
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp_ready  = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;

    // req0 ADD 5+3
    applyStimulus(1, 32'd5, 32'd3, 5'd0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);

    // Contention: req0 SUB 7-7 against req1 SLTU 1<2
    applyStimulus(1, 32'd7, 32'd7, 5'd1, 1, 32'd1, 32'd2, 5'd4, 1, 12);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);

    // Backpressure in RESP
    applyStimulus(1, 32'h1234, 32'h0F0F, 5'd8, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 32'd9, 32'd9, 5'd0, 0, 5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);

    // Illegal opcode on req1, then a legal one
    applyStimulus(0, 0, 0, 0, 1, 32'hDEAD, 32'hBEEF, 5'b10000, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    applyStimulus(0, 0, 0, 0, 1, 32'd10, 32'd4, 5'd1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);

    // Mid-cycle reset with non-zero state: outputs clear at once
    applyStimulus(1, 32'hFFFF0000, 32'h00FF, 5'd8, 0, 0, 0, 0, 0, 3);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("reset_rsp", 80'({rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err}), 80'(0));
    checkOutput("reset_alu", 80'({alu_a, alu_b, alu_op}), 80'(0));
    checkOutput("reset_busy", 80'(busy), 80'(0));
    checkOutput("reset_ready0", 80'(req0_ready), 80'(1));
    req0_valid = 1'b0;
    #1;
    checkOutput("reset_ready0_low", 80'(req0_ready), 80'(0));
    @(negedge clk);
    #3 rst_n = 1'b1;

    // Reset during EXEC discards the op; then req1 XOR alone
    applyStimulus(1, 32'd1, 32'd2, 5'd0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    #3 rst_n = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    applyStimulus(0, 0, 0, 0, 1, 32'hF0, 32'hFF, 5'd5, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);

    // Randomized traffic, including dropped valids and illegal opcodes
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 19)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
                    5'($urandom_range(0, 19)), 1'($urandom_range(0, 3) != 0), 1);
    end

    // Drain with a bounded wait
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 30 && (m_inflight || exp_q.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    checkOutput("drain_queue", 80'(exp_q.size()), 80'(0));
    checkOutput("drain_idle", 80'(busy), 80'(0));

    $display("[TB] %0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
